// File: rtl/alu32_core_if.sv
// Operand/result bundle between the ALU stimulus side and the datapath.
// The master drives operands and opcode; the slave returns the registered
// result and error flag.
interface alu32_core_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       Opcode;
   logic [WIDTH-1:0] Result;
   logic             Error;

   modport master (
      output A,
      output B,
      output Opcode,
      input  Result,
      input  Error
   );

   modport slave (
      input  A,
      input  B,
      input  Opcode,
      output Result,
      output Error
   );
endinterface

// File: rtl/alu32_core.sv
// Single-cycle signed ALU with registered result and error flag.
// All operations, including division, complete combinationally and are
// captured on the rising edge, so a new operation is accepted every cycle.
module alu32_core #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   alu32_core_if.slave alu
);

   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]          sum;
   logic [WIDTH-1:0]          diff;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]          quot;
   logic signed [WIDTH-1:0]   div_b;
   logic                      div_zero;
   logic                      div_ovf;
   logic                      add_ovf;
   logic                      sub_ovf;
   logic                      mul_ovf;
   logic [WIDTH-1:0]          res_nxt;
   logic                      err_nxt;

   assign sum  = alu.A + alu.B;
   assign diff = alu.A - alu.B;
   assign prod = $signed({{WIDTH{alu.A[WIDTH-1]}}, alu.A})
               * $signed({{WIDTH{alu.B[WIDTH-1]}}, alu.B});

   assign add_ovf = (alu.A[WIDTH-1] == alu.B[WIDTH-1]) && (sum[WIDTH-1]  != alu.A[WIDTH-1]);
   assign sub_ovf = (alu.A[WIDTH-1] != alu.B[WIDTH-1]) && (diff[WIDTH-1] != alu.A[WIDTH-1]);
   // Product fits in WIDTH bits only if the top WIDTH+1 bits are a pure sign extension.
   assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));

   assign div_zero = (alu.B == '0);
   assign div_ovf  = (alu.A == MIN_VAL) && (alu.B == ALL_ONES);
   // The divider never sees the two undefined cases; their outputs are forced below.
   assign div_b    = (div_zero || div_ovf) ? $signed(ONE) : $signed(alu.B);
   assign quot     = $signed(alu.A) / div_b;

   // Next result/error select; unknown or reserved opcodes fall into default.
   always_comb begin
      res_nxt = '0;
      err_nxt = 1'b0;
      case (alu.Opcode)
         3'b000: begin
            res_nxt = sum;
            err_nxt = add_ovf;
         end
         3'b001: begin
            res_nxt = diff;
            err_nxt = sub_ovf;
         end
         3'b010: begin
            res_nxt = prod[WIDTH-1:0];
            err_nxt = mul_ovf;
         end
         3'b011: begin
            if (div_zero) begin
               res_nxt = '0;
               err_nxt = 1'b1;
            end else if (div_ovf) begin
               res_nxt = MIN_VAL;
               err_nxt = 1'b1;
            end else begin
               res_nxt = quot;
               err_nxt = 1'b0;
            end
         end
         3'b100: res_nxt = alu.A & alu.B;
         3'b101: res_nxt = alu.A | alu.B;
         3'b110: res_nxt = alu.A ^ alu.B;
         default: begin
            res_nxt = '0;
            err_nxt = 1'b1;
         end
      endcase
   end

   // Output register; reset clears outputs without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu.Result <= '0;
         alu.Error  <= 1'b0;
      end else begin
         alu.Result <= res_nxt;
         alu.Error  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_alu32_core.sv
// Directed bench for alu32_core: reset behaviour, each opcode with its
// boundary cases, then a back-to-back stream checked against a 64-bit model.
module tb_alu32_core;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu32_core_if #(.WIDTH(32)) bus ();

   alu32_core #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .alu (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t stream [20];

   task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_e);
      checks++;
      assert (bus.Result === exp_r) else begin
         errors++;
         $error("FAIL %s result got %h want %h", tag, bus.Result, exp_r);
      end
      checks++;
      assert (bus.Error === exp_e) else begin
         errors++;
         $error("FAIL %s error got %b want %b", tag, bus.Error, exp_e);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [31:0] exp_r, input logic exp_e);
      @(negedge clk);
      bus.A      = a;
      bus.B      = b;
      bus.Opcode = op;
      @(posedge clk);
      #1;
      check(tag, exp_r, exp_e);
   endtask

   // Reference: exact 64-bit arithmetic, error when the true value leaves the 32-bit range.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      longint sa;
      longint sb;
      longint r;
      logic   e;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 0;
      e  = 1'b0;
      case (op)
         3'd0: r = sa + sb;
         3'd1: r = sa - sb;
         3'd2: r = sa * sb;
         3'd3: begin
            if (sb == 0) begin
               r = 0;
               e = 1'b1;
            end else if (sa == -64'sd2147483648 && sb == -1) begin
               r = -64'sd2147483648;
               e = 1'b1;
            end else begin
               r = sa / sb;
            end
         end
         3'd4: r = longint'({32'h0, a & b});
         3'd5: r = longint'({32'h0, a | b});
         3'd6: r = longint'({32'h0, a ^ b});
         default: begin
            r = 0;
            e = 1'b1;
         end
      endcase
      if (op <= 3'd2)
         e = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return {e, r[31:0]};
   endfunction

   initial begin
      logic [32:0] exp;
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      bus.A      = '0;
      bus.B      = '0;
      bus.Opcode = 3'b000;

      stream = '{
         '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001},
         '{3'd0, 32'h0000_0001, 32'h0000_0002},
         '{3'd1, 32'h8000_0000, 32'h0000_0001},
         '{3'd1, 32'h0000_0064, 32'h0000_0032},
         '{3'd2, 32'h0001_0000, 32'h0001_0000},
         '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'd3, 32'h0000_000A, 32'h0000_0000},
         '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002},
         '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd4, 32'h1234_5678, 32'h0F0F_0F0F},
         '{3'd7, 32'h1111_1111, 32'h2222_2222},
         '{3'd5, 32'hA5A5_A5A5, 32'h5A5A_0000},
         '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd6, 32'hDEAD_BEEF, 32'hFFFF_0000},
         '{3'd0, 32'h8000_0000, 32'h8000_0000},
         '{3'd1, 32'h0000_0000, 32'h8000_0000},
         '{3'd3, 32'h7FFF_FFFF, 32'h8000_0000},
         '{3'd2, 32'hFFFF_8000, 32'h0001_0000},
         '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001},
         '{3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF}
      };

      #12;
      check("reset_state", 32'h0, 1'b0);

      // Build a non-zero result, then assert reset mid-cycle.
      @(negedge clk);
      rst = 1'b0;
      run("pre_reset", 32'h0000_1000, 32'h0000_0234, 3'b000, 32'h0000_1234, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run("add_5_7", 32'd5, 32'd7, 3'b000, 32'd12, 1'b0);

      run("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 1'b1);
      run("sub_ovf",   32'h8000_0000, 32'h0000_0001, 3'b001, 32'h7FFF_FFFF, 1'b1);
      run("sub_neg",   32'hFFFF_FFFD, 32'h0000_000A, 3'b001, 32'hFFFF_FFF3, 1'b0);
      run("mul_neg",   32'hFFFF_FFFA, 32'h0000_0007, 3'b010, 32'hFFFF_FFD6, 1'b0);
      run("mul_ovf",   32'h0001_0000, 32'h0001_0000, 3'b010, 32'h0000_0000, 1'b1);
      run("div_trunc", 32'hFFFF_FFF9, 32'h0000_0002, 3'b011, 32'hFFFF_FFFD, 1'b0);
      run("div_zero",  32'h0000_0064, 32'h0000_0000, 3'b011, 32'h0000_0000, 1'b1);
      run("div_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 32'h8000_0000, 1'b1);
      run("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'h00F0_00F0, 1'b0);
      run("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'hFFF0_FFF0, 1'b0);
      run("xor",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b110, 32'hFF00_FF00, 1'b0);
      run("invalid",   32'h1234_5678, 32'h0000_0001, 3'b111, 32'h0000_0000, 1'b1);
      run("err_clear", 32'h0000_0003, 32'h0000_0004, 3'b000, 32'h0000_0007, 1'b0);

      // Back-to-back stream: new operation every falling edge.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.A      = stream[i].a;
         bus.B      = stream[i].b;
         bus.Opcode = stream[i].op;
         exp        = model(stream[i].a, stream[i].b, stream[i].op);
         @(posedge clk);
         #1;
         check($sformatf("stream_%0d", i), exp[31:0], exp[32]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
